// File: rtl/fifosync_pkg.sv
// ---------------------------------------------------------------------------
// fifosync_pkg
// Shared definitions for the programmable synchronous FIFO (fifosync_prog):
//   - fs_width(): ceil(log2(n)) width helper, never smaller than 1
//   - ERR_OVF / ERR_UDF: bit positions of the sticky error flags
//   - DEF_*: default parameter values
// ---------------------------------------------------------------------------
package fifosync_pkg;

    localparam int DEF_DW     = 16;
    localparam int DEF_DEPTH  = 1000;
    localparam int DEF_AEMPTY = 4;

    // Bit positions inside the two-bit sticky error register
    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Number of bits needed to encode values 0..n-1 (minimum one bit)
    function automatic int fs_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifosync_ram.sv
// ---------------------------------------------------------------------------
// fifosync_ram
// DEPTH x DW simple dual-port storage array, no reset.
// Macro FIFOSYNC_PROG_FWFT_EN: defined -> asynchronous read port
//                              undefined -> registered read, updated on re
// Ports:
//   clk    in   clock
//   we     in   write enable      waddr in AW   wdata in DW
//   re     in   read enable (registered-read build only)
//   raddr  in   AW read address   rdata out DW read data
// ---------------------------------------------------------------------------
module fifosync_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 1000,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef FIFOSYNC_PROG_FWFT_EN
    // Head entry is looked at combinationally by the output stage
    assign rdata = mem_q[raddr];

    logic unused_re_s;
    assign unused_re_s = re;
`else
    logic [DW-1:0] rdata_q;

    // Registered read port; holds its value when no read is requested
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/fifosync_prog.sv
// ---------------------------------------------------------------------------
// fifosync_prog
// Single-clock FIFO with arbitrary depth, fill level, almost-full/empty
// thresholds and sticky overflow/underflow flags (cleared by clr_err).
// Macro FIFOSYNC_PROG_FWFT_EN: defined -> first-word-fall-through read mode;
//                              undefined -> one-cycle registered read mode.
// Ports:
//   clk, rst_n (async active-low), clr_err (sync error clear)
//   wr_en, wr_data[DW]         write side
//   rd_en                      read request / FWFT pop
//   rd_data[DW], rd_valid      read side
//   full, empty, almost_full, almost_empty, level[LW]   fill status
//   overflow, underflow        sticky error flags
// ---------------------------------------------------------------------------
module fifosync_prog
    import fifosync_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AFULL  = DEPTH - 4,
    parameter int AEMPTY = DEF_AEMPTY
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_err,
    input  logic                         wr_en,
    input  logic [DW-1:0]                wr_data,
    input  logic                         rd_en,
    output logic [DW-1:0]                rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [fs_width(DEPTH+1)-1:0] level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int LW = fs_width(DEPTH + 1);
    localparam int AW = fs_width(DEPTH);

    // Pointer increment with explicit wrap, DEPTH need not be a power of two
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1'b1);
    endfunction

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    err_q, err_d;

    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          ram_we_s;
    logic          ram_adv_s;
    logic [DW-1:0] ram_rdata_s;

`ifdef FIFOSYNC_PROG_FWFT_EN
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [LW-1:0] ram_cnt_s;
    logic          need_load_s;
    logic          load_ram_s;
    logic          bypass_s;
`else
    logic          rd_valid_q, rd_valid_d;
    // Set by the first accepted read so rd_data reads 0 until then
    logic          rd_seen_q, rd_seen_d;
`endif

    // Status flags decoded from the stored level
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        almost_full  = (level_q >= LW'(AFULL));
        almost_empty = (level_q <= LW'(AEMPTY));
`ifdef FIFOSYNC_PROG_FWFT_EN
        empty        = !out_valid_q;
`else
        empty        = (level_q == '0);
`endif
    end

    // Next-state logic: accept decisions, pointers, level, errors, read stage
    always_comb begin
        wr_acc_s  = wr_en && !full;
`ifdef FIFOSYNC_PROG_FWFT_EN
        // Entries still in the array, excluding the head held in the output register
        ram_cnt_s   = level_q - LW'(out_valid_q);
        rd_acc_s    = rd_en && out_valid_q;
        need_load_s = !out_valid_q || rd_acc_s;
        load_ram_s  = need_load_s && (ram_cnt_s != '0);
        // Nothing queued behind the head: incoming word goes straight to the output
        bypass_s    = need_load_s && (ram_cnt_s == '0) && wr_acc_s;
        ram_we_s    = wr_acc_s && !bypass_s;
        ram_adv_s   = load_ram_s;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load_ram_s) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_rdata_s;
        end else if (bypass_s) begin
            out_valid_d = 1'b1;
            out_data_d  = wr_data;
        end else if (need_load_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
`else
        rd_acc_s   = rd_en && !empty;
        ram_we_s   = wr_acc_s;
        ram_adv_s  = rd_acc_s;
        rd_valid_d = rd_acc_s;
        rd_seen_d  = rd_seen_q || rd_acc_s;
`endif

        wr_ptr_d = wr_ptr_q;
        if (ram_we_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        rd_ptr_d = rd_ptr_q;
        if (ram_adv_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase

        // A new error in the same cycle as clr_err keeps the flag set
        err_d          = err_q;
        err_d[ERR_OVF] = (err_q[ERR_OVF] && !clr_err) || (wr_en && full);
        err_d[ERR_UDF] = (err_q[ERR_UDF] && !clr_err) || (rd_en && empty);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 2'b00;
`ifdef FIFOSYNC_PROG_FWFT_EN
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
`else
            rd_valid_q  <= 1'b0;
            rd_seen_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            err_q       <= err_d;
`ifdef FIFOSYNC_PROG_FWFT_EN
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`else
            rd_valid_q  <= rd_valid_d;
            rd_seen_q   <= rd_seen_d;
`endif
        end
    end

    fifosync_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (ram_adv_s),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata_s)
    );

    assign level     = level_q;
    assign overflow  = err_q[ERR_OVF];
    assign underflow = err_q[ERR_UDF];
`ifdef FIFOSYNC_PROG_FWFT_EN
    assign rd_valid  = out_valid_q;
    assign rd_data   = out_data_q;
`else
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_seen_q ? ram_rdata_s : '0;
`endif

endmodule
